// File: rtl/sc_stream_controller.sv
// sc_stream_controller: seeds an 8-bit LFSR, runs 2^LEN_LOG2 stochastic samples and counts the ones.
// Optional macro SC_ABORT_EN adds an abort input that cancels a run in progress.
module sc_stream_controller #(
    parameter int WIDTH    = 8,
    parameter int LEN_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    seed,
`ifdef SC_ABORT_EN
    input  logic                abort,
`endif
    input  logic                circuit_bit,
    output logic [WIDTH-1:0]    lfsr_state,
    output logic                sc_en,
    output logic                busy,
    output logic                done,
    output logic [LEN_LOG2:0]   result,
    output logic [1:0]          state_dbg
);

    // Handshake: start is a level sampled only in IDLE (no queueing); done is a
    // one-cycle pulse and result stays valid from that cycle until the next done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LFSR_INIT = WIDTH'(1);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      lfsr_q, lfsr_d;
    logic [LEN_LOG2-1:0]   cnt_q, cnt_d;
    logic [LEN_LOG2:0]     acc_q, acc_d;
    logic [LEN_LOG2:0]     result_q, result_d;
    logic                  abort_w;
    logic                  last_sample;
    logic                  fb;

`ifdef SC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last_sample = (cnt_q == {LEN_LOG2{1'b1}});
    assign fb          = lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-2] ^ lfsr_q[1] ^ lfsr_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_INIT;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                // abort wins over the end-of-run transition
                if (abort_w)          state_d = IDLE;
                else if (last_sample) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : datapath_next
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // an all-zero seed would lock the LFSR
                    lfsr_d = (seed == '0) ? LFSR_INIT : seed;
                    cnt_d  = '0;
                    acc_d  = '0;
                end
            end
            RUN: begin
                if (!abort_w) begin
                    lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + LEN_LOG2'(1);
                    acc_d  = acc_q + (LEN_LOG2+1)'(circuit_bit);
                    if (last_sample) result_d = acc_d;
                end
            end
            default: ;
        endcase
    end

    always_comb begin : outputs
        sc_en = (state_q == RUN);
        busy  = (state_q == RUN) || (state_q == DONE);
        done  = (state_q == DONE);
    end

    assign lfsr_state = lfsr_q;
    assign result     = result_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_sc_stream_controller.sv
// Bench for sc_stream_controller: random seeds and random circuit truth tables against
// a reference model that predicts the visited LFSR states and the ones count.
module tb_sc_stream_controller;

    localparam int WIDTH    = 8;
    localparam int LEN_LOG2 = 8;
    localparam int N        = 1 << LEN_LOG2;

    localparam int K_NONE  = 0;
    localparam int K_START = 1;
    localparam int K_RST   = 2;
    localparam int K_ABORT = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                start;
    logic [WIDTH-1:0]    seed;
    logic                circuit_bit;
    logic [WIDTH-1:0]    lfsr_state;
    logic                sc_en;
    logic                busy;
    logic                done;
    logic [LEN_LOG2:0]   result;
    logic [1:0]          state_dbg;
`ifdef SC_ABORT_EN
    logic                abort;
`endif

    sc_stream_controller #(.WIDTH(WIDTH), .LEN_LOG2(LEN_LOG2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
`ifdef SC_ABORT_EN
        .abort       (abort),
`endif
        .circuit_bit (circuit_bit),
        .lfsr_state  (lfsr_state),
        .sc_en       (sc_en),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .state_dbg   (state_dbg)
    );

    // circuit stand-in: 0 = tied low, 1 = tied high, 2 = LSB of state, 3 = random truth table
    int   mode;
    logic tt [256];

    function automatic logic model_bit(input int m, input logic [WIDTH-1:0] s);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return s[0];
            default: return tt[s];
        endcase
    endfunction

    always_comb circuit_bit = model_bit(mode, lfsr_state);

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        int v, f;
        v = int'(s);
        f = ((v >> 7) ^ (v >> 6) ^ (v >> 1) ^ v) & 1;
        return WIDTH'((v >> 1) | (f << 7));
    endfunction

    // scoreboard
    logic [WIDTH-1:0] exp_q[$];
    int               exp_result;
    int               n_checks;
    int               n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [WIDTH-1:0] exp_lfsr);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_sc_en"}, 32'(sc_en),      32'd0);
        check({tag, "_state"}, 32'(state_dbg),  32'd0);
        check({tag, "_result"}, 32'(result),    32'(exp_result));
        check({tag, "_lfsr"},  32'(lfsr_state), 32'(exp_lfsr));
    endtask

    // one run: seed s, circuit mode m, optional event of kind at sample index ev
    task automatic do_run(input logic [WIDTH-1:0] s, input int m, input int ev, input int kind);
        logic [WIDTH-1:0] st;
        logic [WIDTH-1:0] seen;
        int               ones;
        int               done_k;
        mode = m;
        exp_q.delete();
        ones = 0;
        st   = (s == 0) ? WIDTH'(1) : s;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(st);
            ones += int'(model_bit(m, st));
            st = lfsr_next(st);
        end
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        done_k = 0;
        for (int k = 1; k <= N + 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_k = k;
                break;
            end
            check("run_sc_en", 32'(sc_en), 32'd1);
            check("run_busy",  32'(busy),  32'd1);
            seen = lfsr_state;
            if (exp_q.size() > 0) check("run_lfsr", 32'(lfsr_state), 32'(exp_q.pop_front()));
            if (kind == K_START && k - 1 == ev) start = 1'b1;
            if (kind == K_RST && k - 1 == ev) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_result = 0;
                check_idle("rst_mid", WIDTH'(1));
                return;
            end
`ifdef SC_ABORT_EN
            if (kind == K_ABORT && k - 1 == ev) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_idle("abort", seen);
                return;
            end
`endif
        end
        check("done_latency", 32'(done_k), 32'(N + 1));
        check("done_busy",    32'(busy),   32'd1);
        check("done_sc_en",   32'(sc_en),  32'd0);
        check("done_result",  32'(result), 32'(ones));
        check("done_lfsr",    32'(lfsr_state), 32'(st));
        exp_result = ones;
        @(negedge clk);
        check_idle("after_done", st);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_result = 0;
        mode       = 0;
        rst        = 1'b1;
        start      = 1'b0;
        seed       = '0;
`ifdef SC_ABORT_EN
        abort      = 1'b0;
`endif
        for (int i = 0; i < 256; i++) tt[i] = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        check_idle("reset", WIDTH'(1));
        rst = 1'b0;

        do_run(8'h01, 1, -1, K_NONE);
        do_run(8'h01, 0, -1, K_NONE);
        do_run(8'h00, 0, -1, K_NONE);
        do_run(8'h01, 2, 60, K_START);
        do_run(8'h01, 1, 100, K_RST);
        do_run(8'(32'($urandom_range(0, 255))), 3, -1, K_NONE);
`ifdef SC_ABORT_EN
        do_run(8'(32'($urandom_range(1, 255))), 3, 50, K_ABORT);
`endif
        for (int r = 0; r < 3; r++)
            do_run(8'(32'($urandom_range(0, 255))), 3, $urandom_range(1, 250), K_START);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
